// File: rtl/pattern_detector_param_if.sv
// Bus bundle for the parametrised serial pattern detector.
// Carries the qualified bit stream, the configuration load port, the counter clear and the detector outputs.
// The master drives the stream and configuration; the slave (detector) drives match, match_cnt and armed.
interface pattern_detector_param_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
);
    logic             in_valid;
    logic             in_bit;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_ovl;
    logic             cnt_clr;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             armed;

    modport master (
        output in_valid, in_bit, cfg_load, cfg_pat, cfg_len, cfg_ovl, cnt_clr,
        input  match, match_cnt, armed
    );

    modport slave (
        input  in_valid, in_bit, cfg_load, cfg_pat, cfg_len, cfg_ovl, cnt_clr,
        output match, match_cnt, armed
    );
endinterface

// File: rtl/pattern_detector_param.sv
// Serial bit-pattern detector with a runtime-loadable 1..PAT_W bit pattern, overlap select and saturating hit counter.
// Latency: match pulses the cycle after the edge that accepts the completing bit; match_cnt updates on that edge.
// No backpressure: a bit is consumed whenever in_valid is high; cfg_load wins over a same-cycle bit, which is dropped.
module pattern_detector_param #(
    parameter int               PAT_W   = 8,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(8'b0011_0101),
    parameter int               DEF_LEN = 6,
    parameter bit               DEF_OVL = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    pattern_detector_param_if.slave bus
);
    localparam int               LEN_W    = $clog2(PAT_W + 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] LEN_RST  = LEN_W'(DEF_LEN);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_ARMED   = 2'd2
    } state_t;

    // Active configuration
    logic [PAT_W-1:0] pat, pat_next;
    logic [LEN_W-1:0] len, len_next;
    logic             ovl, ovl_next;

    // History and detection progress
    logic [PAT_W-1:0] hist, hist_next;
    logic [LEN_W-1:0] fill, fill_next, fill_inc;
    state_t           st, st_next;

    // Compare window and hit
    logic [PAT_W-1:0] len_mask;
    logic             hit;

    // Registered outputs
    logic             match_q;
    logic [CNT_W-1:0] cnt_q;

    // Out-of-range lengths fall back to the full pattern width
    logic [LEN_W-1:0] cfg_len_clamped;
    always_comb begin
        cfg_len_clamped = bus.cfg_len;
        if (bus.cfg_len == '0 || bus.cfg_len > LEN_MAX) begin
            cfg_len_clamped = LEN_MAX;
        end
    end

    // Mask selecting the low len bits of the history for comparison
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len));
        end
    end

    // Next-state: config load, history shift, fill tracking and hit evaluation
    always_comb begin
        pat_next  = pat;
        len_next  = len;
        ovl_next  = ovl;
        hist_next = hist;
        fill_next = fill;
        fill_inc  = fill;
        hit       = 1'b0;
        if (bus.cfg_load) begin
            pat_next  = bus.cfg_pat;
            len_next  = cfg_len_clamped;
            ovl_next  = bus.cfg_ovl;
            hist_next = '0;
            fill_next = '0;
        end else if (bus.in_valid) begin
            hist_next = (hist << 1) | PAT_W'(bus.in_bit);
            fill_inc  = (fill == LEN_MAX) ? fill : fill + LEN_W'(1);
            hit       = (fill_inc >= len) && (((hist_next ^ pat) & len_mask) == '0);
            // Non-overlapping hits restart the fill so the next match needs len fresh bits
            fill_next = (hit && !ovl) ? '0 : fill_inc;
        end
        if (fill_next == '0) begin
            st_next = ST_EMPTY;
        end else if (fill_next >= len_next) begin
            st_next = ST_ARMED;
        end else begin
            st_next = ST_FILLING;
        end
    end

    // State register: configuration, history, fill and detection state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat  <= DEF_PAT;
            len  <= LEN_RST;
            ovl  <= DEF_OVL;
            hist <= '0;
            fill <= '0;
            st   <= ST_EMPTY;
        end else begin
            pat  <= pat_next;
            len  <= len_next;
            ovl  <= ovl_next;
            hist <= hist_next;
            fill <= fill_next;
            st   <= st_next;
        end
    end

    // Match pulse and saturating hit counter; clear beats a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            match_q <= hit;
            if (bus.cnt_clr) begin
                cnt_q <= '0;
            end else if (hit && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Outputs come straight from registers
    always_comb begin
        bus.armed     = (st == ST_ARMED);
        bus.match     = match_q;
        bus.match_cnt = cnt_q;
    end
endmodule

// File: tb/tb_pattern_detector_param.sv
// Directed self-checking bench for pattern_detector_param.
// Main instance uses CNT_W=8; a second instance with CNT_W=2 exercises counter saturation.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_pattern_detector_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pattern_detector_param_if #(.PAT_W(8), .CNT_W(8)) bus1 ();
    pattern_detector_param_if #(.PAT_W(8), .CNT_W(2)) bus2 ();

    pattern_detector_param #(.PAT_W(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    pattern_detector_param #(.PAT_W(8), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load1(input logic [7:0] p, input logic [3:0] l, input logic o);
        bus1.cfg_load = 1'b1;
        bus1.cfg_pat  = p;
        bus1.cfg_len  = l;
        bus1.cfg_ovl  = o;
        tick();
        bus1.cfg_load = 1'b0;
    endtask

    // Streams n bits MSB-first on consecutive cycles, checking match/armed after each accepting edge
    task automatic run_seq(input string tag, input logic [15:0] bits, input int n,
                           input logic [15:0] em, input logic [15:0] ea);
        for (int i = 0; i < n; i++) begin
            bus1.in_valid = 1'b1;
            bus1.in_bit   = bits[n-1-i];
            tick();
            chk($sformatf("%s.match%0d", tag, i), bus1.match, em[n-1-i]);
            chk($sformatf("%s.armed%0d", tag, i), bus1.armed, ea[n-1-i]);
        end
        bus1.in_valid = 1'b0;
    endtask

    initial begin
        logic [5:0] dpat;
        dpat = 6'b110101;
        bus1.in_valid = 0; bus1.in_bit = 0; bus1.cfg_load = 0; bus1.cfg_pat = '0;
        bus1.cfg_len  = '0; bus1.cfg_ovl = 0; bus1.cnt_clr = 0;
        bus2.in_valid = 0; bus2.in_bit = 0; bus2.cfg_load = 0; bus2.cfg_pat = '0;
        bus2.cfg_len  = '0; bus2.cfg_ovl = 0; bus2.cnt_clr = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.match", bus1.match, 0);
        chk("rst.cnt",   bus1.match_cnt, 0);
        chk("rst.armed", bus1.armed, 0);
        rst = 1'b0;
        tick();

        // Default pattern 110101
        run_seq("def", 16'b110101, 6, 16'b000001, 16'b000001);
        chk("def.cnt", bus1.match_cnt, 1);
        tick();
        chk("def.idle_match", bus1.match, 0);
        chk("def.idle_armed", bus1.armed, 1);

        // Overlap mode, pattern 1011
        load1(8'b0000_1011, 4'd4, 1'b1);
        chk("ovl.armed_after_load", bus1.armed, 0);
        run_seq("ovl", 16'b1011011, 7, 16'b0001001, 16'b0001111);
        chk("ovl.cnt", bus1.match_cnt, 3);

        // Non-overlap mode, same pattern and stream
        load1(8'b0000_1011, 4'd4, 1'b0);
        run_seq("novl", 16'b1011011, 7, 16'b0001000, 16'b0000000);
        chk("novl.cnt", bus1.match_cnt, 4);

        // Valid gaps: 3 idle cycles after each bit, with the idle bit inverted
        load1(8'b0011_0101, 4'd6, 1'b1);
        for (int i = 0; i < 6; i++) begin
            bus1.in_valid = 1'b1;
            bus1.in_bit   = dpat[5-i];
            tick();
            chk($sformatf("gap.match%0d", i), bus1.match, (i == 5) ? 1 : 0);
            bus1.in_valid = 1'b0;
            bus1.in_bit   = ~dpat[5-i];
            for (int g = 0; g < 3; g++) begin
                tick();
                chk($sformatf("gap.idle%0d_%0d", i, g), bus1.match, 0);
            end
        end
        chk("gap.cnt", bus1.match_cnt, 5);

        // cfg_load on the completing bit drops it and clears history
        load1(8'b0011_0101, 4'd6, 1'b1);
        run_seq("prio", 16'b11010, 5, 16'b00000, 16'b00000);
        bus1.in_valid = 1'b1;
        bus1.in_bit   = 1'b1;
        load1(8'b0011_0101, 4'd6, 1'b1);
        bus1.in_valid = 1'b0;
        chk("prio.match", bus1.match, 0);
        chk("prio.armed", bus1.armed, 0);
        chk("prio.cnt",   bus1.match_cnt, 5);
        run_seq("prio_after", 16'b1, 1, 16'b0, 16'b0);

        // cnt_clr on a hit: match still pulses, count goes to 0
        load1(8'b0011_0101, 4'd6, 1'b1);
        run_seq("clr", 16'b11010, 5, 16'b00000, 16'b00000);
        bus1.cnt_clr  = 1'b1;
        bus1.in_valid = 1'b1;
        bus1.in_bit   = 1'b1;
        tick();
        bus1.cnt_clr  = 1'b0;
        bus1.in_valid = 1'b0;
        chk("clr.match", bus1.match, 1);
        chk("clr.cnt",   bus1.match_cnt, 0);

        // cfg_len of 0 is taken as the full 8-bit pattern
        load1(8'b1010_1010, 4'd0, 1'b1);
        run_seq("len0", 16'b10101010, 8, 16'b00000001, 16'b00000001);
        chk("len0.cnt", bus1.match_cnt, 1);

        // len=1 overlapping: back-to-back matches
        load1(8'b0000_0001, 4'd1, 1'b1);
        run_seq("len1", 16'b1101, 4, 16'b1101, 16'b1111);
        chk("len1.cnt", bus1.match_cnt, 4);

        // Saturation on the CNT_W=2 instance
        bus2.cfg_load = 1'b1;
        bus2.cfg_pat  = 8'b0000_0001;
        bus2.cfg_len  = 4'd1;
        bus2.cfg_ovl  = 1'b1;
        tick();
        bus2.cfg_load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus2.in_valid = 1'b1;
            bus2.in_bit   = 1'b1;
            tick();
            chk($sformatf("sat.cnt%0d", i), bus2.match_cnt, (i < 3) ? i + 1 : 3);
        end
        bus2.in_valid = 1'b0;

        // Asynchronous reset mid-stream after a custom pattern
        load1(8'b0000_1011, 4'd4, 1'b1);
        run_seq("arst_pre", 16'b10, 2, 16'b00, 16'b00);
        rst = 1'b1;
        #3;
        chk("arst.match", bus1.match, 0);
        chk("arst.cnt",   bus1.match_cnt, 0);
        chk("arst.armed", bus1.armed, 0);
        chk("arst.cnt2",  bus2.match_cnt, 0);
        #2;
        rst = 1'b0;
        tick();
        run_seq("arst_post", 16'b110101, 6, 16'b000001, 16'b000001);
        chk("arst_post.cnt", bus1.match_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/pattern_detector_param.md
# pattern_detector_param

Parametrised serial bit-pattern detector, the successor to the fixed 110101 detector FSM. It supports a runtime-loadable pattern of 1..PAT_W bits, selectable overlapping or non-overlapping matching, and input qualification by a valid strobe. It also keeps a saturating match counter. It sits on a serial bit stream behind a line receiver and flags each occurrence of the programmed pattern to downstream control logic.

## Interface
- PAT_W, 8: maximum pattern length in bits (≥2).
- CNT_W, 8: match counter width.
- DEF_PAT, 8'b0011_0101: pattern loaded at reset, right-aligned. Default is 110101 with DEF_LEN=6.
- DEF_LEN, 6: pattern length loaded at reset.
- DEF_OVL, 1: overlap mode loaded at reset (1 = overlapping).
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- in_valid, input, 1: in_bit is sampled only when high.
- in_bit, input, 1: serial data bit.
- cfg_load, input, 1: one-cycle strobe that latches cfg_pat, cfg_len and cfg_ovl.
- cfg_pat, input, PAT_W: pattern, right-aligned. cfg_pat[len-1] is the first bit received and cfg_pat[0] the last.
- cfg_len, input, $clog2(PAT_W+1): pattern length.
- cfg_ovl, input, 1: overlap mode.
- cnt_clr, input, 1: synchronous clear of match_cnt.
- match, output, 1: registered one-cycle pulse per detected occurrence.
- match_cnt, output, CNT_W: number of matches, saturating.
- armed, output, 1: high when the history holds at least len valid bits.

## Operation
- Registers:
  - active pattern (pat), length (len) and overlap mode (ovl)
  - PAT_W-bit history shift register (hist)
  - fill counter, 0..PAT_W
  - match and match_cnt
- Accepted bit (in_valid=1, cfg_load=0):
  - hist shifts as hist_next = {hist[PAT_W-2:0], in_bit}.
  - fill increments, saturating at PAT_W.
- Hit condition: fill_next ≥ len and hist_next[len-1:0] == pat[len-1:0]. Bits above len are ignored.
- On a hit:
  - match is set to 1 on the next edge.
  - match_cnt increments, saturating at all-ones.
  - Overlap mode: fill continues normally.
  - Non-overlap mode: fill is forced to 0, so the next match needs len fresh bits.
- When in_valid=0: hist and fill hold, and match goes to 0.
- cfg_load:
  - Latches cfg_pat, cfg_len and cfg_ovl.
  - Clears hist and fill.
  - match_cnt is not affected.
  - cfg_load has priority over in_valid: a bit presented in the same cycle is dropped and match is 0.
  - A cfg_len of 0 or greater than PAT_W is latched as PAT_W.
- Detection states, derived from fill:
  - EMPTY: fill=0.
  - FILLING: 0 < fill < len.
  - ARMED: fill ≥ len.
  - Transitions: EMPTY→FILLING on an accepted bit (or EMPTY→ARMED directly when len=1). FILLING→ARMED when fill reaches len. ARMED→EMPTY on a non-overlap hit. Any state→EMPTY on cfg_load.
  - armed = (fill ≥ len), registered.
- cnt_clr has priority over an increment in the same cycle: match_cnt becomes 0. match still pulses.

## Timing
- Reset values: match=0, match_cnt=0, armed=0, hist=0, fill=0, pat=DEF_PAT, len=DEF_LEN, ovl=DEF_OVL.
- Latency: match is high in the cycle after the edge that accepts the completing bit. match_cnt updates on that same edge.
- Back-to-back matches are possible every cycle (overlap mode with len=1, or with a pattern such as all-ones).
- New configuration takes effect for the first bit accepted after the cfg_load edge.
- Asserting rst mid-stream immediately returns every register to its reset value, including the configuration. An in-flight match pulse is killed.
- No combinational path from inputs to outputs.

## Test plan
- Reset defaults: stream 110101 on consecutive valid cycles → match pulses once, one cycle after the 6th bit. match_cnt=1. armed goes high together with that bit's fill reaching 6.
- Overlap mode: load pat=1011, len=4, ovl=1, then stream 1011011 → match after bit 4 and after bit 7. match_cnt=2.
- Non-overlap mode: same pattern with ovl=0 and the same stream → match only after bit 4. match_cnt=1. armed drops after the hit.
- Valid gaps: default pattern with in_valid low for 3 cycles between each bit → exactly one match, one cycle after the final valid bit. Bits held while invalid are not counted.
- Priority and saturation:
  - cfg_load in the same cycle as the completing bit → no match, history cleared.
  - cnt_clr in the same cycle as a hit → match=1, match_cnt=0.
  - CNT_W=2 with 5 matches → match_cnt stays at 3.
- Async reset: assert rst for half a cycle while in FILLING after loading a custom pattern → outputs return to zero immediately. pat reverts to DEF_PAT, and 110101 is detected again.
